// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine between EX and WB.
// Issues one handshaked request per load/store on the data RAM port and stalls
// the upstream pipeline until ram_ready. Store data is replicated across byte
// lanes, and load data is aligned and extended before it is registered into the
// write-back bundle.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned accesses.
// A rejected access issues no bus request and pulses misalign_error.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [3:0]            mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic                  reg_write_en_in,
  input  logic [4:0]            reg_write_addr_in,
  input  logic [ADDR_WIDTH-1:0] current_pc_addr_in,
  output logic                  stall_request,
  output logic                  ram_en,
  output logic [3:0]            ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  reg_write_en_out,
  output logic [4:0]            reg_write_addr_out,
  output logic [ADDR_WIDTH-1:0] current_pc_addr_out
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  misalign_error
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state;

  // Transaction latched at issue; held while the RAM is busy.
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [3:0]            sel_p1;
  logic                  store_p1;
  logic                  sext_p1;
  logic                  we_p1;
  logic [4:0]            waddr_p1;
  logic [ADDR_WIDTH-1:0] pc_p1;

  logic mem_op;
  logic op_go;
  logic op_bad;

  // Index of the lowest enabled byte lane.
  function automatic logic [1:0] low_lane(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    if (sel[0])      idx = 2'd0;
    else if (sel[1]) idx = 2'd1;
    else if (sel[2]) idx = 2'd2;
    else if (sel[3]) idx = 2'd3;
    return idx;
  endfunction

  // Number of enabled byte lanes.
  function automatic logic [2:0] lane_count(input logic [3:0] sel);
    return 3'(sel[0]) + 3'(sel[1]) + 3'(sel[2]) + 3'(sel[3]);
  endfunction

  // Replicate right-justified store data onto every lane it could target.
  function automatic logic [31:0] replicate(input logic [3:0] sel, input logic [31:0] data);
    logic [31:0] r;
    case (lane_count(sel))
      3'd1:    r = {4{data[7:0]}};
      3'd2:    r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  // Right-align the selected lanes of the read word and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [3:0] sel, input logic [31:0] rdata,
                                          input logic sext);
    logic [31:0] shifted;
    logic [31:0] r;
    shifted = rdata >> {low_lane(sel), 3'b000};
    case (lane_count(sel))
      3'd1:    r = {{24{sext & shifted[7]}}, shifted[7:0]};
      3'd2:    r = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: r = shifted;
    endcase
    return r;
  endfunction

  // Legal lane pattern for the byte offset of the address.
  function automatic logic is_aligned(input logic [3:0] sel, input logic [1:0] offs);
    return ((sel == 4'b1111) && (offs == 2'd0)) ||
           ((sel == 4'b0011) && (offs == 2'd0)) ||
           ((sel == 4'b1100) && (offs == 2'd2)) ||
           (sel == (4'b0001 << offs));
  endfunction

  assign mem_op = mem_read_flag | mem_write_flag;

`ifdef MEM_ALIGN_CHECK_EN
  assign op_bad = mem_op & ~is_aligned(mem_sel, alu_result[1:0]);
`else
  assign op_bad = 1'b0;
`endif
  assign op_go = mem_op & ~op_bad;

  // Stall on issue (same cycle) and until the RAM completes.
  always_comb begin
    stall_request = 1'b0;
    if (state == IDLE) stall_request = op_go;
    else               stall_request = ~ram_ready;
  end

  // Control FSM with registered bus request and write-back bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      ram_en              <= 1'b0;
      ram_write_en        <= 4'b0000;
      ram_addr            <= '0;
      ram_write_data      <= '0;
      result              <= '0;
      reg_write_en_out    <= 1'b0;
      reg_write_addr_out  <= 5'd0;
      current_pc_addr_out <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_error      <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      misalign_error <= (state == IDLE) & op_bad;
`endif
      case (state)
        IDLE: begin
          if (op_go) begin
            // Issue boundary: latch the transaction, request from next cycle.
            addr_p1          <= alu_result;
            sel_p1           <= mem_sel;
            store_p1         <= mem_write_flag;
            sext_p1          <= mem_sign_ext_flag;
            we_p1            <= reg_write_en_in;
            waddr_p1         <= reg_write_addr_in;
            pc_p1            <= current_pc_addr_in;
            ram_en           <= 1'b1;
            ram_write_en     <= mem_write_flag ? mem_sel : 4'b0000;
            ram_addr         <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
            ram_write_data   <= replicate(mem_sel, mem_write_data);
            reg_write_en_out <= 1'b0;
            state            <= BUSY;
          end else begin
            result              <= DATA_WIDTH'(alu_result);
            reg_write_en_out    <= reg_write_en_in & ~op_bad;
            reg_write_addr_out  <= reg_write_addr_in;
            current_pc_addr_out <= current_pc_addr_in;
          end
        end
        BUSY: begin
          if (ram_ready) begin
            // Retire boundary: release the bus and register write-back.
            ram_en              <= 1'b0;
            ram_write_en        <= 4'b0000;
            result              <= store_p1 ? DATA_WIDTH'(addr_p1)
                                            : extract(sel_p1, ram_read_data, sext_p1);
            reg_write_en_out    <= store_p1 ? 1'b0 : we_p1;
            reg_write_addr_out  <= waddr_p1;
            current_pc_addr_out <= pc_p1;
            state               <= IDLE;
          end else begin
            reg_write_en_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a write-back scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data, alu_result, current_pc_addr_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic        stall_request, ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        ram_ready;
  logic [31:0] result, current_pc_addr_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_error;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
  } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
    .mem_write_data(mem_write_data), .alu_result(alu_result),
    .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
    .current_pc_addr_in(current_pc_addr_in), .stall_request(stall_request),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .ram_ready(ram_ready), .result(result), .reg_write_en_out(reg_write_en_out),
    .reg_write_addr_out(reg_write_addr_out), .current_pc_addr_out(current_pc_addr_out)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_error(misalign_error)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_read_flag = 0; mem_write_flag = 0; mem_sign_ext_flag = 0;
    mem_sel = 4'b0000; mem_write_data = 0; alu_result = 0;
    reg_write_en_in = 0; reg_write_addr_in = 0; current_pc_addr_in = 0;
  endtask

  task automatic push(input logic [31:0] res, input logic we, input logic [4:0] wa,
                      input logic [31:0] pc);
    wb_t e;
    e.res = res; e.we = we; e.wa = wa; e.pc = pc;
    sb.push_back(e);
  endtask

  // Compare the current write-back outputs against the oldest expectation.
  task automatic pop_check(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_we"}, 32'(reg_write_en_out), 32'(e.we));
      chk({tag, "_waddr"}, 32'(reg_write_addr_out), 32'(e.wa));
      chk({tag, "_pc"}, current_pc_addr_out, e.pc);
    end
  endtask

  task automatic do_nonmem(input string tag, input logic [31:0] alu, input logic we,
                           input logic [4:0] wa, input logic [31:0] pc);
    drive_idle();
    alu_result = alu; reg_write_en_in = we; reg_write_addr_in = wa; current_pc_addr_in = pc;
    push(alu, we, wa, pc);
    #1 chk({tag, "_stall"}, 32'(stall_request), 32'd0);
    tick();
    chk({tag, "_stall_after"}, 32'(stall_request), 32'd0);
    pop_check(tag);
  endtask

  // One memory op: present it, hold ram_ready low for 'waits' BUSY cycles, then complete.
  task automatic do_mem(input string tag, input logic rd, input logic wr, input logic sx,
                        input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_ram_addr, input logic [3:0] exp_bwe,
                        input logic [31:0] exp_bdata, input logic [31:0] exp_res,
                        input logic exp_we, input logic [4:0] wa, input logic [31:0] pc);
    int stalls;
    mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sx; mem_sel = sel;
    mem_write_data = wdata; alu_result = addr; reg_write_en_in = 1'b1;
    reg_write_addr_in = wa; current_pc_addr_in = pc;
    push(exp_res, exp_we, wa, pc);
    stalls = 0;
    #1 chk({tag, "_stall_c0"}, 32'(stall_request), 32'd1);
    if (stall_request === 1'b1) stalls++;
    tick();
    drive_idle();
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, "_ram_addr"}, ram_addr, exp_ram_addr);
    chk({tag, "_ram_we"}, 32'(ram_write_en), 32'(exp_bwe));
    if (exp_bwe != 4'b0000) chk({tag, "_ram_wdata"}, ram_write_data, exp_bdata);
    chk({tag, "_bubble"}, 32'(reg_write_en_out), 32'd0);
    for (int i = 0; i < waits; i++) begin
      ram_ready = 1'b0;
      #1;
      if (stall_request === 1'b1) stalls++;
      if (i == waits - 1) chk({tag, "_ram_en_held"}, 32'(ram_en), 32'd1);
      tick();
    end
    ram_ready = 1'b1; ram_read_data = rdata;
    #1 chk({tag, "_stall_ck"}, 32'(stall_request), 32'd0);
    tick();
    ram_ready = 1'b0; ram_read_data = 32'h0;
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 1));
    chk({tag, "_ram_en_done"}, 32'(ram_en), 32'd0);
    pop_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ram_ready = 0; ram_read_data = 0;
    drive_idle();
    tick(); tick();
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_write_en), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_write_data, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_we", 32'(reg_write_en_out), 32'd0);
    chk("rst_pc", current_pc_addr_out, 32'd0);
    chk("rst_stall", 32'(stall_request), 32'd0);
    rst = 0;

    do_nonmem("nonmem", 32'h0000_1234, 1'b1, 5'd5, 32'h0000_0040);
    do_nonmem("nonmem2", 32'hDEAD_BEEF, 1'b0, 5'd31, 32'h0000_0044);

    do_mem("lb_s", 1, 0, 1, 4'b1000, 32'h0000_0103, 32'h0, 3, 32'h80FF_FF00,
           32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1, 5'd7, 32'h0000_0048);
    do_mem("lhu", 1, 0, 0, 4'b1100, 32'h0000_0102, 32'h0, 0, 32'hBEEF_0000,
           32'h0000_0100, 4'b0000, 32'h0, 32'h0000_BEEF, 1'b1, 5'd8, 32'h0000_004C);
    // back-to-back with the previous op: no gap cycle
    do_mem("sb", 0, 1, 0, 4'b0010, 32'h0000_0201, 32'h0000_00AB, 0, 32'h0,
           32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0000_0201, 1'b0, 5'd9, 32'h0000_0050);
    do_mem("lh_s", 1, 0, 1, 4'b0011, 32'h0000_0300, 32'h0, 1, 32'h1234_8001,
           32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b1, 5'd10, 32'h0000_0054);
    do_mem("lbu", 1, 0, 0, 4'b0100, 32'h0000_0402, 32'h0, 2, 32'h00C3_0000,
           32'h0000_0400, 4'b0000, 32'h0, 32'h0000_00C3, 1'b1, 5'd11, 32'h0000_0058);
    do_mem("lw", 1, 0, 1, 4'b1111, 32'h0000_0500, 32'h0, 0, 32'h8765_4321,
           32'h0000_0500, 4'b0000, 32'h0, 32'h8765_4321, 1'b1, 5'd12, 32'h0000_005C);
    do_mem("sh", 0, 1, 0, 4'b1100, 32'h0000_0602, 32'h0000_5A6B, 1, 32'h0,
           32'h0000_0600, 4'b1100, 32'h5A6B_5A6B, 32'h0000_0602, 1'b0, 5'd13, 32'h0000_0060);
    // read and write both set behaves as a store
    do_mem("rw_sw", 1, 1, 0, 4'b1111, 32'h0000_0700, 32'h1122_3344, 0, 32'hFFFF_FFFF,
           32'h0000_0700, 4'b1111, 32'h1122_3344, 32'h0000_0700, 1'b0, 5'd14, 32'h0000_0064);

    // reset while a load is outstanding
    mem_read_flag = 1; mem_sel = 4'b1111; alu_result = 32'h0000_0800;
    reg_write_en_in = 1; reg_write_addr_in = 5'd15; current_pc_addr_in = 32'h68;
    tick();
    drive_idle();
    chk("rstmid_busy", 32'(ram_en), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rstmid_ram_en", 32'(ram_en), 32'd0);
    chk("rstmid_stall", 32'(stall_request), 32'd0);
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_we", 32'(reg_write_en_out), 32'd0);
    chk("rstmid_waddr", 32'(reg_write_addr_out), 32'd0);
    chk("rstmid_pc", current_pc_addr_out, 32'd0);
    ram_ready = 1; ram_read_data = 32'hCAFE_F00D;
    #1 chk("late_ready_stall", 32'(stall_request), 32'd0);
    tick();
    ram_ready = 0;
    chk("late_ready_we", 32'(reg_write_en_out), 32'd0);
    chk("late_ready_result", result, 32'd0);
    chk("late_ready_ram_en", 32'(ram_en), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    mem_read_flag = 1; mem_sel = 4'b1111; alu_result = 32'h0000_0102;
    reg_write_en_in = 1; reg_write_addr_in = 5'd16; current_pc_addr_in = 32'h6C;
    #1 chk("mis_stall", 32'(stall_request), 32'd0);
    tick();
    drive_idle();
    chk("mis_ram_en", 32'(ram_en), 32'd0);
    chk("mis_err", 32'(misalign_error), 32'd1);
    chk("mis_we", 32'(reg_write_en_out), 32'd0);
    tick();
    chk("mis_err_pulse", 32'(misalign_error), 32'd0);
    chk("mis_ram_en2", 32'(ram_en), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
